// File: rtl/seq_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu_pkg : shared types for the handshaked sequential ALU         |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package seq_alu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SHL  = 4'h5,
    ALU_SHR  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_MUL  = 4'hA
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
    logic illegal;
  } flags_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_hs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu_hs_if : request/result handshake bundle of the sequential ALU|
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
interface seq_alu_hs_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Carry;
  logic             Overflow;
  logic             Negative;
  logic             Illegal;
  logic             busy;

  modport master (
    output in_valid, opcode, A, B, out_ready,
    input  in_ready, out_valid, Result, Zero, Carry, Overflow, Negative,
           Illegal, busy
  );

  modport slave (
    input  in_valid, opcode, A, B, out_ready,
    output in_ready, out_valid, Result, Zero, Carry, Overflow, Negative,
           Illegal, busy
  );
endinterface
`default_nettype wire

// File: rtl/seq_alu_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu_mul_iter : shift-add multiplier, one partial product / cycle |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module seq_alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             hi_nonzero_o
);
  localparam int CNT_W = $clog2(WIDTH);

  logic               active_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_nx;

  // Upper half accumulates, lower half holds the multiplier bits still to consume.
  always_comb begin
    add_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
            + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_nx = {add_sum, prod_q[WIDTH-1:1]};
  end

  // Outputs show the post-step product so the caller can register it on the final edge.
  assign done_o       = active_q && (cnt_q == CNT_W'(WIDTH-1));
  assign lo_o         = prod_nx[WIDTH-1:0];
  assign hi_nonzero_o = |prod_nx[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      mcand_q  <= a_i;
      prod_q   <= {{WIDTH{1'b0}}, b_i};
    end else if (active_q) begin
      prod_q <= prod_nx;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (done_o) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_alu_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_alu_hs : valid/ready sequential ALU; iterative MUL built only    |
// |              when SEQ_ALU_MUL_EN is defined                          |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module seq_alu_hs
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_alu_hs_if.slave bus_s
);
  localparam int SHAMT_W = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    flags_t           fl;
  } alu_out_t;

  function automatic alu_out_t alu_eval(input logic [3:0]       op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
    alu_out_t           o;
    logic [WIDTH:0]     ext;
    logic [SHAMT_W-1:0] sh;
    o   = '0;
    ext = '0;
    sh  = b[SHAMT_W-1:0];
    case (op)
      ALU_ADD: begin
        ext        = {1'b0, a} + {1'b0, b};
        o.res      = ext[WIDTH-1:0];
        o.fl.carry = ext[WIDTH];
        o.fl.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        ext        = {1'b0, a} - {1'b0, b};
        o.res      = ext[WIDTH-1:0];
        o.fl.carry = ext[WIDTH];
        o.fl.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (o.res[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  o.res = a & b;
      ALU_OR:   o.res = a | b;
      ALU_XOR:  o.res = a ^ b;
      ALU_SHL:  o.res = a << sh;
      ALU_SHR:  o.res = a >> sh;
      ALU_SRA:  o.res = $signed(a) >>> sh;
      ALU_SLT:  o.res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: o.res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  o.fl.illegal = 1'b1;
    endcase
    o.fl.zero     = (o.res == '0);
    o.fl.negative = o.res[WIDTH-1];
    return o;
  endfunction

  state_e           st_q, st_d;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;
  logic             in_ready, out_valid, busy;
  logic             accept, is_mul;
  alu_out_t         alu_w;
  logic             mul_done, mul_hi_nz;
  logic [WIDTH-1:0] mul_lo;
  flags_t           mul_fl;

  assign accept = bus_s.in_valid & in_ready;
  assign alu_w  = alu_eval(bus_s.opcode, bus_s.A, bus_s.B);

`ifdef SEQ_ALU_MUL_EN
  assign is_mul = (bus_s.opcode == ALU_MUL);

  seq_alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (accept & is_mul),
    .a_i          (bus_s.A),
    .b_i          (bus_s.B),
    .done_o       (mul_done),
    .lo_o         (mul_lo),
    .hi_nonzero_o (mul_hi_nz)
  );
`else
  assign is_mul    = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_lo    = '0;
  assign mul_hi_nz = 1'b0;
`endif

  always_comb begin
    mul_fl          = '0;
    mul_fl.zero     = (mul_lo == '0);
    mul_fl.overflow = mul_hi_nz;
    mul_fl.negative = mul_lo[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      ST_IDLE: if (accept) st_d = is_mul ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_done) st_d = ST_HOLD;
      ST_HOLD: begin
        if (accept)               st_d = is_mul ? ST_MUL : ST_HOLD;
        else if (bus_s.out_ready) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (st_q)
      ST_IDLE: in_ready = 1'b1;
`ifdef SEQ_ALU_MUL_EN
      ST_MUL:  busy = 1'b1;
`endif
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = bus_s.out_ready;
      end
      default: ;
    endcase
  end

  // Result and flags change only on completion, so they stay put under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
    end else if (mul_done) begin
      result_q <= mul_lo;
      flags_q  <= mul_fl;
    end else if (accept && !is_mul) begin
      result_q <= alu_w.res;
      flags_q  <= alu_w.fl;
    end
  end

  assign bus_s.in_ready  = in_ready;
  assign bus_s.out_valid = out_valid;
  assign bus_s.busy      = busy;
  assign bus_s.Result    = result_q;
  assign bus_s.Zero      = flags_q.zero;
  assign bus_s.Carry     = flags_q.carry;
  assign bus_s.Overflow  = flags_q.overflow;
  assign bus_s.Negative  = flags_q.negative;
  assign bus_s.Illegal   = flags_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_hs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_alu_hs : directed and random stimulus against a reference     |
// |                 model of the handshaked sequential ALU               |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module tb_seq_alu_hs;
  localparam int     W    = 8;
  localparam longint FULL = longint'(1) << W;
  localparam longint HALF = longint'(1) << (W - 1);
  localparam longint MASK = FULL - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  seq_alu_hs_if #(.WIDTH(W)) bus ();

  seq_alu_hs #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus_s (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint to_signed(input longint v);
    return (v >= HALF) ? v - FULL : v;
  endfunction

  // Flag vector order: {Zero, Carry, Overflow, Negative, Illegal}
  function automatic void model(input int op, input longint a, input longint b,
                                output longint res, output logic [4:0] fl);
    longint sa, sb, full, sres;
    int     sh;
    logic   c, v, ill;
    sa = to_signed(a);
    sb = to_signed(b);
    sh = int'(b % W);
    c = 1'b0; v = 1'b0; ill = 1'b0; full = 0;
    case (op)
      0: begin full = a + b; c = (full > MASK); sres = sa + sb; v = (sres >= HALF) || (sres < -HALF); end
      1: begin full = a - b; c = (a < b);       sres = sa - sb; v = (sres >= HALF) || (sres < -HALF); end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = a << sh;
      6: full = a >> sh;
      7: full = sa >>> sh;
      8: full = (sa < sb) ? 1 : 0;
      9: full = (a < b) ? 1 : 0;
`ifdef SEQ_ALU_MUL_EN
      10: begin full = a * b; v = ((full >> W) != 0); end
`endif
      default: ill = 1'b1;
    endcase
    res = full & MASK;
    fl  = {(res == 0), c, v, (((res >> (W - 1)) & 1) == 1), ill};
  endfunction

  function automatic logic [4:0] dut_flags();
    return {bus.Zero, bus.Carry, bus.Overflow, bus.Negative, bus.Illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int op, input longint a, input longint b);
    bus.in_valid = 1'b1;
    bus.opcode   = 4'(op);
    bus.A        = a[W-1:0];
    bus.B        = b[W-1:0];
  endtask

  task automatic scramble_req();
    bus.in_valid = 1'b0;
    bus.opcode   = 4'($urandom);
    bus.A        = W'($urandom);
    bus.B        = W'($urandom);
  endtask

  task automatic do_op(input int op, input longint a, input longint b, input int hold);
    longint     er;
    logic [4:0] ef;
    int         lat, exp_lat;
    model(op, a, b, er, ef);
    exp_lat = 1;
`ifdef SEQ_ALU_MUL_EN
    if (op == 10) exp_lat = W + 1;
`endif
    drive_req(op, a, b);
    lat = 0;
    while (!bus.in_ready && lat < 50) begin tick(); lat++; end
    check("in_ready", bus.in_ready, 1);
    tick();
    scramble_req();
    if (exp_lat > 1) check("busy", {bus.busy, bus.in_ready}, 2'b10);
    lat = 1;
    while (!bus.out_valid && lat < 3 * W) begin tick(); lat++; end
    check("latency", lat, exp_lat);
    check("result", bus.Result, er);
    check("flags", dut_flags(), ef);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("hold_state", {bus.out_valid, bus.in_ready}, 2'b10);
        check("hold_result", {bus.Result, dut_flags()}, {er[W-1:0], ef});
      end
      bus.out_ready = 1'b1;
    end
    tick();
    check("drain_valid", bus.out_valid, 0);
  endtask

  initial begin
    longint     er1, er2;
    logic [4:0] ef1, ef2;

    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.A         = '0;
    bus.B         = '0;
    bus.out_ready = 1'b1;

    repeat (2) tick();
    check("rst_outputs", {bus.Result, dut_flags(), bus.out_valid, bus.busy}, '0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    tick();

    do_op(0, 'h7F, 'h01, 0);
    do_op(1, 'h05, 'h07, 1);
    do_op(7, 'h80, 'h03, 0);
    do_op(8, 'h80, 'h01, 0);
    do_op(9, 'h80, 'h01, 0);
    do_op(10, 'h10, 'h11, 0);
    do_op(15, 'h33, 'h44, 0);

    // Back-to-back: ADD FF+01 then AND 0F&F0 accepted on the delivery edge
    model(0, 'hFF, 'h01, er1, ef1);
    model(2, 'h0F, 'hF0, er2, ef2);
    drive_req(0, 'hFF, 'h01);
    tick();
    drive_req(2, 'h0F, 'hF0);
    check("b2b_first", {bus.out_valid, bus.in_ready, bus.Result, dut_flags()}, {2'b11, er1[W-1:0], ef1});
    tick();
    scramble_req();
    check("b2b_second", {bus.out_valid, bus.Result, dut_flags()}, {1'b1, er2[W-1:0], ef2});
    tick();
    check("b2b_drain", bus.out_valid, 0);

    // Backpressure with a pending OR request
    model(4, 'hAA, 'h55, er1, ef1);
    model(3, 'h12, 'h21, er2, ef2);
    bus.out_ready = 1'b0;
    drive_req(4, 'hAA, 'h55);
    tick();
    drive_req(3, 'h12, 'h21);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold", {bus.out_valid, bus.in_ready, bus.Result}, {2'b10, er1[W-1:0]});
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    tick();
    scramble_req();
    check("bp_pending", {bus.out_valid, bus.Result, dut_flags()}, {1'b1, er2[W-1:0], ef2});
    tick();
    check("bp_drain", bus.out_valid, 0);

    // Reset during the 4th cycle after a MUL is accepted
    bus.out_ready = 1'b0;
    drive_req(10, 'h10, 'h11);
    tick();
    scramble_req();
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {bus.Result, dut_flags(), bus.out_valid, bus.busy}, '0);
    check("midrst_in_ready", bus.in_ready, 1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("postrst_idle", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
    end
    bus.out_ready = 1'b1;
    do_op(0, 'h02, 'h03, 0);

    for (int i = 0; i < 60; i++) begin
      int op;
      op = (i % 5 == 0) ? 10 : int'($urandom_range(15, 0));
      do_op(op, longint'($urandom) & MASK, longint'($urandom) & MASK,
            int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu_hs.md
Name: seq_alu_hs

Overview:
Parametrised, handshaked successor to the 8-bit sequential ALU.
- Operand width is set by a parameter.
- valid/ready is used on both input and output, so backpressure is supported.
- Shift, compare and iterative multiply operations are added.
- Zero, carry, overflow and negative flags always describe the result being delivered.
- Sits between the datapath sequencer and the register-file writeback.

Parameters:
WIDTH, 8, operand/result width in bits; must be a power of two and at least 4.
SHAMT_W, $clog2(WIDTH), localparam giving the shift-amount width taken from B[SHAMT_W-1:0].

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request this cycle
opcode  in  4  operation select
A  in  WIDTH  operand A
B  in  WIDTH  operand B
out_valid  out  1  Result and flags are valid
out_ready  in  1  consumer accepts the result
Result  out  WIDTH  operation result
Zero  out  1  Result == 0
Carry  out  1  unsigned carry-out for ADD; borrow for SUB
Overflow  out  1  signed overflow for ADD/SUB; product high half nonzero for MUL
Negative  out  1  Result[WIDTH-1]
Illegal  out  1  unsupported opcode was executed
busy  out  1  multiply in progress

Behaviour:
- Reset: all outputs go to 0 and state goes to IDLE. Reset asserted mid-MUL aborts the operation; no result is produced.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SHL, 0110 SHR (logical), 0111 SRA; shift amount is B[SHAMT_W-1:0].
  - 1000 SLT (signed) and 1001 SLTU: Result = {0..0, A<B}.
  - 1010 MUL: low WIDTH bits of A*B.
  - Any other opcode: Result=0, Zero=1, Illegal=1.
- Flags:
  - Carry and Overflow are 0 for every operation except ADD, SUB and MUL (Overflow only for MUL).
  - Zero and Negative are always computed from the new Result, never from the previous one.
  - Illegal is 0 except for an illegal opcode.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - MUL: in_ready=0, busy=1.
  - HOLD: out_valid=1; in_ready = out_ready.
- Transfer rules: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
- Single-cycle operations:
  - Result and flags are registered on the acceptance edge; next state is HOLD.
  - out_valid is high in the cycle after acceptance (latency 1).
- MUL:
  - Acceptance latches the operands, clears the accumulator and the counter, and enters MUL.
  - One shift-add step per cycle; on the WIDTH-th step edge the result is registered and the state moves to HOLD.
  - out_valid rises WIDTH+1 cycles after acceptance.
  - The counter wraps only through reset or completion.
- HOLD:
  - Result and flags stay stable while out_ready=0.
  - On out_ready: if in_valid also, the new request is accepted on the same edge (back-to-back, 1 op/cycle for single-cycle ops; a MUL goes to MUL and out_valid drops). Otherwise go to IDLE.
- Requests in the MUL state are ignored, because in_ready=0.
- Opcode, A and B are sampled only on the acceptance edge; later changes do not matter.

Optional Feature:
Macro SEQ_ALU_MUL_EN.
- Defined: opcode 1010 executes the iterative MUL, with the MUL state, counter and busy behaviour as above.
- Undefined: 1010 is treated as illegal with 1-cycle latency. No multiplier logic or counter is built, and busy is tied to 0.

Decomposition:
- Package seq_alu_pkg holds:
  - the opcode enum (ALU_ADD..ALU_MUL);
  - the state enum (ST_IDLE, ST_MUL, ST_HOLD);
  - the flag-vector struct {Zero, Carry, Overflow, Negative, Illegal}.
- One sub-module, seq_alu_mul_iter:
  - Takes start, A and B; produces done, lo[WIDTH] and hi_nonzero.
  - Instantiated only under SEQ_ALU_MUL_EN.
- All single-cycle ops are a combinational function inside the top.

Test Plan:
- ADD 7F+01, out_ready=1 -> next cycle out_valid=1, Result=80, Overflow=1, Carry=0, Negative=1, Zero=0.
- ADD FF+01 -> Result=00, Zero=1, Carry=1, Overflow=0; then AND 0F&F0 back-to-back -> Result=00, Zero=1, Carry=0 on the following cycle.
- SUB 05-07 -> FE, Carry=1, Negative=1, Overflow=0; SRA 80 by B=03 -> F0; SLT 80,01 -> 01; SLTU 80,01 -> 00.
- Backpressure: out_ready=0 for 3 cycles after XOR AA^55 -> Result=FF held stable, in_ready=0; on out_ready=1 with a pending OR request, that request is accepted on the same edge.
- MUL 10*11 (macro on) -> busy for 8 cycles, out_valid 9 cycles after accept, Result=10, Overflow=1. Macro off -> 1 cycle later Result=00, Zero=1, Illegal=1.
- rst_n low during the 4th MUL cycle -> all outputs 0 and in_ready=1 after release; the next ADD 02+03 returns 05.
